// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the background-removal processing element.
//   - one-hot state encodings (IDLE/LOAD/RUN/DONE) and the FSM state type
//   - operating mode constants (SUM / BG)
//   - width helpers for the index, per-channel sum and squared-distance buses
package pe_pkg;

  localparam logic [3:0] ST_IDLE_OH = 4'b0001;
  localparam logic [3:0] ST_LOAD_OH = 4'b0010;
  localparam logic [3:0] ST_RUN_OH  = 4'b0100;
  localparam logic [3:0] ST_DONE_OH = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = ST_IDLE_OH,
    ST_LOAD = ST_LOAD_OH,
    ST_RUN  = ST_RUN_OH,
    ST_DONE = ST_DONE_OH
  } state_e;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_BG  = 1'b1;

  // Pixel index width; a single-pixel build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough that n full-scale samples can never wrap.
  function automatic int sum_width(input int cw, input int n);
    return cw + $clog2(n + 1);
  endfunction

  // Three squared CW-bit differences fit in 2*CW+2 bits.
  function automatic int dist_width(input int cw);
    return 2 * cw + 2;
  endfunction

endpackage

// File: rtl/pe_dist_sq.sv
// pe_dist_sq: combinational squared colour distance.
//   o_dist = |r-re|^2 + |g-ge|^2 + |b-be|^2, computed in DW bits.
// Ports:
//   i_r/i_g/i_b     CW  pixel colour
//   i_re/i_ge/i_be  CW  reference colour
//   o_dist          DW  squared distance
module pe_dist_sq #(
  parameter int CW = 8,
  parameter int DW = 2 * CW + 2
) (
  input  logic [CW-1:0] i_r,
  input  logic [CW-1:0] i_g,
  input  logic [CW-1:0] i_b,
  input  logic [CW-1:0] i_re,
  input  logic [CW-1:0] i_ge,
  input  logic [CW-1:0] i_be,
  output logic [DW-1:0] o_dist
);

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [DW-1:0] w_dr;
  logic [DW-1:0] w_dg;
  logic [DW-1:0] w_db;

  assign w_dr = {{(DW-CW){1'b0}}, abs_diff(i_r, i_re)};
  assign w_dg = {{(DW-CW){1'b0}}, abs_diff(i_g, i_ge)};
  assign w_db = {{(DW-CW){1'b0}}, abs_diff(i_b, i_be)};

  assign o_dist = (w_dr * w_dr) + (w_dg * w_dg) + (w_db * w_db);

endmodule

// File: rtl/pe_bgrem_seq.sv
// pe_bgrem_seq: sequential multi-pixel processing element.
// Captures NUM_PIXELS packed RGB pixels on Start, then processes one pixel
// per clock either as a per-channel sum (Mode=0) or as a background test
// with colour replacement (Mode=1). Results are held until Ack in DONE.
// Optional macro PE_BG_COUNT_EN adds bg_count (replaced-pixel counter).
// Ports:
//   Clk, Reset (async, active-high)
//   Start, Mode, Ack                 control handshake
//   red_in/green_in/blue_in          packed pixels, pixel k at [k*CW +: CW]
//   red_exp/green_exp/blue_exp       expected background colour
//   threshold                        squared-distance threshold (DW)
//   bg_r/bg_g/bg_b                   replacement colour
//   red_out/green_out/blue_out       processed pixels, same packing
//   red_sum/green_sum/blue_sum       channel sums (SW)
//   Busy, Done, state_q              status; state_q one-hot {DONE,RUN,LOAD,IDLE}
//   bg_count                         (PE_BG_COUNT_EN only) replaced-pixel count
module pe_bgrem_seq
  import pe_pkg::*;
#(
  parameter int NUM_PIXELS = 4,
  parameter int CW = 8,
  localparam int CNTW = idx_width(NUM_PIXELS),
  localparam int SW = sum_width(CW, NUM_PIXELS),
  localparam int DW = dist_width(CW)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Mode,
  input  logic                     Ack,
  input  logic [CW*NUM_PIXELS-1:0] red_in,
  input  logic [CW*NUM_PIXELS-1:0] green_in,
  input  logic [CW*NUM_PIXELS-1:0] blue_in,
  input  logic [CW-1:0]            red_exp,
  input  logic [CW-1:0]            green_exp,
  input  logic [CW-1:0]            blue_exp,
  input  logic [DW-1:0]            threshold,
  input  logic [CW-1:0]            bg_r,
  input  logic [CW-1:0]            bg_g,
  input  logic [CW-1:0]            bg_b,
  output logic [CW*NUM_PIXELS-1:0] red_out,
  output logic [CW*NUM_PIXELS-1:0] green_out,
  output logic [CW*NUM_PIXELS-1:0] blue_out,
  output logic [SW-1:0]            red_sum,
  output logic [SW-1:0]            green_sum,
  output logic [SW-1:0]            blue_sum,
  output logic                     Busy,
  output logic                     Done,
  output logic [3:0]               state_q
`ifdef PE_BG_COUNT_EN
  ,
  output logic [CNTW:0]            bg_count
`endif
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_mode;
  logic [CNTW-1:0]         r_idx;
  logic [CW*NUM_PIXELS-1:0] r_buf_r, r_buf_g, r_buf_b;
  logic [CW*NUM_PIXELS-1:0] r_red_out, r_green_out, r_blue_out;
  logic [SW-1:0]           r_red_sum, r_green_sum, r_blue_sum;
  logic [CW-1:0]           w_pix_r, w_pix_g, w_pix_b;
  logic [DW-1:0]           w_dist;
  logic                    w_replace;
  logic                    w_last;
`ifdef PE_BG_COUNT_EN
  logic [CNTW:0]           r_bg_count;
`endif

  // Select the pixel currently addressed by the run index.
  always_comb begin
    w_pix_r = r_buf_r[r_idx*CW +: CW];
    w_pix_g = r_buf_g[r_idx*CW +: CW];
    w_pix_b = r_buf_b[r_idx*CW +: CW];
  end

  pe_dist_sq #(.CW(CW), .DW(DW)) u_dist (
    .i_r   (w_pix_r),
    .i_g   (w_pix_g),
    .i_b   (w_pix_b),
    .i_re  (red_exp),
    .i_ge  (green_exp),
    .i_be  (blue_exp),
    .o_dist(w_dist)
  );

  // Equality counts as background.
  assign w_replace = (r_mode == MODE_BG) && (w_dist <= threshold);
  assign w_last    = (r_idx == CNTW'(NUM_PIXELS - 1));

  // Next-state logic; Ack beats a simultaneous Start in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) w_state_nxt = ST_LOAD;
        else       w_state_nxt = ST_IDLE;
      end
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (Ack) w_state_nxt = ST_IDLE;
        else     w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered Busy/Done decoded from the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Capture on Start, then one pixel slot (and sums) updated per RUN cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode      <= MODE_SUM;
      r_idx       <= '0;
      r_buf_r     <= '0;
      r_buf_g     <= '0;
      r_buf_b     <= '0;
      r_red_out   <= '0;
      r_green_out <= '0;
      r_blue_out  <= '0;
      r_red_sum   <= '0;
      r_green_sum <= '0;
      r_blue_sum  <= '0;
`ifdef PE_BG_COUNT_EN
      r_bg_count  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_mode      <= Mode;
            r_buf_r     <= red_in;
            r_buf_g     <= green_in;
            r_buf_b     <= blue_in;
            r_idx       <= '0;
            r_red_sum   <= '0;
            r_green_sum <= '0;
            r_blue_sum  <= '0;
`ifdef PE_BG_COUNT_EN
            r_bg_count  <= '0;
`endif
          end
        end
        ST_RUN: begin
          r_red_out[r_idx*CW +: CW]   <= w_replace ? bg_r : w_pix_r;
          r_green_out[r_idx*CW +: CW] <= w_replace ? bg_g : w_pix_g;
          r_blue_out[r_idx*CW +: CW]  <= w_replace ? bg_b : w_pix_b;
          if (r_mode == MODE_SUM) begin
            r_red_sum   <= r_red_sum   + {{(SW-CW){1'b0}}, w_pix_r};
            r_green_sum <= r_green_sum + {{(SW-CW){1'b0}}, w_pix_g};
            r_blue_sum  <= r_blue_sum  + {{(SW-CW){1'b0}}, w_pix_b};
          end
`ifdef PE_BG_COUNT_EN
          if (w_replace) r_bg_count <= r_bg_count + {{CNTW{1'b0}}, 1'b1};
`endif
          if (!w_last) r_idx <= r_idx + {{(CNTW-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  assign red_out   = r_red_out;
  assign green_out = r_green_out;
  assign blue_out  = r_blue_out;
  assign red_sum   = r_red_sum;
  assign green_sum = r_green_sum;
  assign blue_sum  = r_blue_sum;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign state_q   = r_state;
`ifdef PE_BG_COUNT_EN
  assign bg_count  = r_bg_count;
`endif

endmodule

// File: tb/tb_pe_bgrem_seq.sv
// tb_pe_bgrem_seq: directed self-checking bench for pe_bgrem_seq
// (NUM_PIXELS=4, CW=8). Expected values are hand-computed constants.
module tb_pe_bgrem_seq;

  localparam int NP   = 4;
  localparam int CW   = 8;
  localparam int CNTW = 2;
  localparam int SW   = 11;
  localparam int DW   = 18;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            Mode = 1'b0;
  logic            Ack = 1'b0;
  logic [CW*NP-1:0] red_in = '0, green_in = '0, blue_in = '0;
  logic [CW-1:0]   red_exp = '0, green_exp = '0, blue_exp = '0;
  logic [DW-1:0]   threshold = '0;
  logic [CW-1:0]   bg_r = '0, bg_g = '0, bg_b = '0;
  logic [CW*NP-1:0] red_out, green_out, blue_out;
  logic [SW-1:0]   red_sum, green_sum, blue_sum;
  logic            Busy, Done;
  logic [3:0]      state_q;
`ifdef PE_BG_COUNT_EN
  logic [CNTW:0]   bg_count;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  pe_bgrem_seq #(.NUM_PIXELS(NP), .CW(CW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Mode     (Mode),
    .Ack      (Ack),
    .red_in   (red_in),
    .green_in (green_in),
    .blue_in  (blue_in),
    .red_exp  (red_exp),
    .green_exp(green_exp),
    .blue_exp (blue_exp),
    .threshold(threshold),
    .bg_r     (bg_r),
    .bg_g     (bg_g),
    .bg_b     (bg_b),
    .red_out  (red_out),
    .green_out(green_out),
    .blue_out (blue_out),
    .red_sum  (red_sum),
    .green_sum(green_sum),
    .blue_sum (blue_sum),
    .Busy     (Busy),
    .Done     (Done),
    .state_q  (state_q)
`ifdef PE_BG_COUNT_EN
    ,
    .bg_count (bg_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_op(input logic m);
    Mode  = m;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && Done !== 1'b1; i++) step();
    check(tag, Done, 1'b1);
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  initial begin
    // Reset values while Reset is held
    #12;
    check("rst_state", state_q, 4'b0001);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_sum", red_sum, 11'd0);
    check("rst_out", red_out, 32'h0);
    Reset = 1'b0;
    step();

    // SUM: red {40,30,20,10}, green {1,2,3,4}, blue 4x100
    red_in   = 32'h281E140A;
    green_in = 32'h01020304;
    blue_in  = 32'h64646464;
    start_op(1'b0);
    check("sum_load_state", state_q, 4'b0010);
    check("sum_load_busy", Busy, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("sum_done_early", Done, 1'b0);
    check("sum_run_state", state_q, 4'b0100);
    step();
    check("sum_done_lat6", Done, 1'b1);
    check("sum_done_state", state_q, 4'b1000);
    check("sum_done_busy", Busy, 1'b0);
    check("sum_red", red_sum, 11'd100);
    check("sum_green", green_sum, 11'd10);
    check("sum_blue", blue_sum, 11'd400);
    check("sum_out_r", red_out, 32'h281E140A);
    check("sum_out_g", green_out, 32'h01020304);
    check("sum_out_b", blue_out, 32'h64646464);

    // Hold DONE for 10 cycles while pulsing Start with changed inputs
    red_in = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      Start = i[0];
      step();
      check("hold_state", state_q, 4'b1000);
    end
    check("hold_out", red_out, 32'h281E140A);
    check("hold_sum", red_sum, 11'd100);
    // Ack together with Start: Ack wins
    Ack = 1'b1;
    Start = 1'b1;
    step();
    check("ack_idle", state_q, 4'b0001);
    check("ack_done_low", Done, 1'b0);
    Ack = 1'b0;
    Start = 1'b0;
    step();
    check("ack_no_start", state_q, 4'b0001);
    check("ack_held_sum", red_sum, 11'd100);
    check("ack_held_out", red_out, 32'h281E140A);

    // SUM full scale: 4x255 = 1020, no wrap
    red_in   = 32'hFFFFFFFF;
    green_in = 32'hFFFFFFFF;
    blue_in  = 32'hFFFFFFFF;
    start_op(1'b0);
    wait_done("ff_done");
    check("ff_red", red_sum, 11'd1020);
    check("ff_green", green_sum, 11'd1020);
    check("ff_blue", blue_sum, 11'd1020);
    do_ack();

    // BG: exp (0,255,0), thr 300, bg (0,0,0)
    // p0 (10,245,5) d=225 bg; p1 (20,235,0) d=800 fg;
    // p2 (10,245,10) d=300 bg; p3 (200,0,200) fg
    red_exp   = 8'd0;
    green_exp = 8'd255;
    blue_exp  = 8'd0;
    threshold = 18'd300;
    bg_r = 8'd0;
    bg_g = 8'd0;
    bg_b = 8'd0;
    red_in   = 32'hC80A140A;
    green_in = 32'h00F5EBF5;
    blue_in  = 32'hC80A0005;
    start_op(1'b1);
    wait_done("bg_done");
    check("bg_out_r", red_out, 32'hC8001400);
    check("bg_out_g", green_out, 32'h0000EB00);
    check("bg_out_b", blue_out, 32'hC8000000);
    check("bg_sum_r", red_sum, 11'd0);
    check("bg_sum_b", blue_sum, 11'd0);
`ifdef PE_BG_COUNT_EN
    check("bg_count", bg_count, 3'd2);
`endif
    do_ack();

    // Reset during RUN at index 2
    red_in   = 32'h04030201;
    green_in = 32'h04030201;
    blue_in  = 32'h04030201;
    start_op(1'b0);
    step();
    step();
    step();
    check("mid_partial_sum", red_sum, 11'd3);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_state", state_q, 4'b0001);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    check("mid_rst_sum", red_sum, 11'd0);
    check("mid_rst_out", red_out, 32'h0);
    #2 Reset = 1'b0;
    step();
    start_op(1'b0);
    wait_done("post_done");
    check("post_sum", red_sum, 11'd10);
    check("post_out", red_out, 32'h04030201);
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_bgrem_seq.md
Name: pe_bgrem_seq

Overview:
Parametrised successor of the single-pixel processing element. Captures a packed block of NUM_PIXELS RGB pixels on Start, then processes one pixel per clock in one of two modes: SUM (per-channel accumulation) or BG (squared-distance background test with colour replacement). Results are held until the control unit acknowledges. Sits between the frame controller and the pixel memory, one instance per pixel lane group.

Parameters:
NUM_PIXELS, 4, pixels handled per Start (>=1)
CW, 8, bits per colour channel
CNTW, $clog2(NUM_PIXELS) min 1, pixel index width (localparam)
SW, CW+$clog2(NUM_PIXELS+1), per-channel sum width (localparam)
DW, 2*CW+2, squared-distance and threshold width (localparam)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  begin operation; sampled only in IDLE
Mode  in  1  0 = SUM, 1 = BG; latched with Start
Ack  in  1  release results; sampled only in DONE
red_in/green_in/blue_in  in  CW*NUM_PIXELS each  packed pixels, pixel k at [k*CW +: CW]
red_exp/green_exp/blue_exp  in  CW each  expected background colour
threshold  in  DW  squared-distance threshold
bg_r/bg_g/bg_b  in  CW each  replacement colour
red_out/green_out/blue_out  out  CW*NUM_PIXELS each  processed pixels, same packing
red_sum/green_sum/blue_sum  out  SW each  channel sums
Busy  out  1  high in LOAD or RUN
Done  out  1  high in DONE
state_q  out  4  one-hot {DONE, RUN, LOAD, IDLE}

Behaviour:
- Reset (asynchronous): state IDLE; all pixel outputs, sums and index cleared to 0; Busy = 0, Done = 0, state_q = 4'b0001.
- IDLE: Start = 1 -> latch Mode, copy red/green/blue_in into an internal buffer, clear sums and index -> LOAD. Inputs may change after this edge.
- LOAD: one cycle to settle the buffer -> RUN.
- RUN: one pixel per cycle, index 0 .. NUM_PIXELS-1. When index == NUM_PIXELS-1 -> DONE; otherwise index increments.
- SUM mode: each channel sum += buffer[index]. Sums are zero-extended to SW, so overflow is impossible. Pixel outputs = unmodified buffer.
- BG mode: dist = (r-re)^2 + (g-ge)^2 + (b-be)^2. Each difference is an absolute difference in CW bits; the sum is computed in DW bits.
  - dist > threshold -> foreground, pixel written unchanged.
  - dist <= threshold (equality counts as background) -> pixel replaced by bg_r/g/b.
  - Sums hold 0 in BG mode.
- Outputs are registered per pixel slot as each pixel is processed. All slots are final on entry to DONE.
- Latency: Start edge to Done high = NUM_PIXELS+2 cycles.
- DONE: outputs and sums held stable. Ack = 1 -> IDLE, results still held until the next Start.
- Start outside IDLE and Ack outside DONE are ignored. Start and Ack together in DONE: Ack wins -> IDLE, Start not honoured that cycle.
- Mode, exp, threshold and bg inputs must be stable from Start to DONE. Exp, threshold and bg are sampled live in RUN.
- Reset mid-operation aborts immediately to the reset values; no partial Done.

Optional Feature:
Macro PE_BG_COUNT_EN.
- Defined: adds output bg_count (width CNTW+1). Cleared on Start, incremented for each pixel replaced in BG mode, held through DONE, reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package pe_pkg holds:
  - state encoding localparams (IDLE/LOAD/RUN/DONE one-hot);
  - MODE_SUM/MODE_BG constants;
  - width helper function for SW/DW.
- One sub-module, pe_dist_sq: combinational squared-distance unit with CW/DW parameters, three channel pairs in, DW out. Verified standalone.

Test Plan:
- SUM, NUM_PIXELS=4, CW=8, red_in = {40,30,20,10} -> red_sum = 100; Done high exactly 6 cycles after Start; outputs equal inputs.
- SUM, all channels 255 -> each sum = 1020 (SW = 11), no wrap.
- BG, exp = (0,255,0), threshold = 300, bg = (0,0,0):
  - (10,245,5), dist 225 -> 0,0,0;
  - (20,235,0), dist 800 -> unchanged;
  - (10,245,10), dist 300 -> replaced (equality boundary).
- Hold Done 10 cycles without Ack while pulsing Start -> state stays DONE, outputs stable; Ack -> IDLE the next cycle; new Start accepted.
- Assert Reset during RUN at index 2 -> state_q = 0001, Busy = 0, sums/outputs = 0 asynchronously; the following Start completes normally.
- With PE_BG_COUNT_EN, the BG vector above plus one foreground pixel -> bg_count = 2; without the macro, the build elaborates with no bg_count port.
